// File: rtl/rom_stream_reader_if.sv
// Request, ROM read port and output stream of rom_stream_reader.
// `ROM_READER_CHKSUM_EN adds the chksum signal.
interface rom_stream_reader_if #(
    parameter int width = 8,
    parameter int depth = 16
);
    localparam int AW = $clog2(depth);

    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW:0]       count;
    logic              busy;
    logic              done;
    logic              en;
    logic [AW-1:0]     addr;
    logic [width-1:0]  dout;
    logic [width-1:0]  m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
`ifdef ROM_READER_CHKSUM_EN
    logic [width-1:0]  chksum;
`endif

    modport master (
        input  start, base_addr, count, dout, m_ready,
        output busy, done, en, addr, m_data, m_valid, m_last
`ifdef ROM_READER_CHKSUM_EN
        , output chksum
`endif
    );

    modport slave (
        output start, base_addr, count, dout, m_ready,
        input  busy, done, en, addr, m_data, m_valid, m_last
`ifdef ROM_READER_CHKSUM_EN
        , input chksum
`endif
    );
endinterface

// File: rtl/rom_stream_reader.sv
// Burst reader for a single-port ROM with 1-cycle read latency, delivering words on a valid/ready stream.
// `ROM_READER_CHKSUM_EN adds a per-burst running XOR output (chksum).
module rom_stream_reader #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_stream_reader_if.master  bus
);
    localparam int AW = $clog2(depth);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        if (a == AW'(depth - 1)) return '0;
        return a + 1'b1;
    endfunction

    state_t            r_state, w_state_nxt;
    logic              r_en, w_en_nxt;
    logic              r_en_last, w_en_last_nxt;
    logic [AW-1:0]     r_addr, w_addr_nxt;
    logic [AW-1:0]     r_nxt_addr, w_nxt_addr_nxt;
    logic [AW:0]       r_remain, w_remain_nxt;
    logic              r_done, w_done_nxt;
    logic              w_burst_start;

    logic              r_rd_vld_p1;
    logic              r_rd_last_p1;

    logic [width-1:0]  r_data;
    logic              r_valid;
    logic              r_last;
    logic [width-1:0]  r_fmem [2];
    logic              r_flast [2];
    logic              r_wp, r_rp;
    logic [1:0]        r_fcnt;

    logic              w_pop;
    logic              w_head_free;
    logic              w_take_fifo;
    logic              w_take_push;
    logic              w_fifo_push;
    logic [2:0]        w_occ;
    logic              w_room;

    assign w_pop       = r_valid & bus.m_ready;
    assign w_head_free = ~r_valid | w_pop;
    assign w_take_fifo = w_head_free & (r_fcnt != 2'd0);
    assign w_take_push = w_head_free & (r_fcnt == 2'd0) & r_rd_vld_p1;
    assign w_fifo_push = r_rd_vld_p1 & ~w_take_push;

    // Everything stored or still in flight after this edge; a new read adds one
    // more, and the presented word plus the 2-entry FIFO hold at most three.
    assign w_occ  = 3'(r_valid) + 3'(r_fcnt) + 3'(r_rd_vld_p1) + 3'(r_en) - 3'(w_pop);
    assign w_room = (w_occ < 3'd3);

    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = 1'b0;
        w_en_last_nxt  = 1'b0;
        w_addr_nxt     = r_addr;
        w_nxt_addr_nxt = r_nxt_addr;
        w_remain_nxt   = r_remain;
        w_done_nxt     = 1'b0;
        w_burst_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_burst_start = 1'b1;
                    if (bus.count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_en_nxt       = 1'b1;
                        w_en_last_nxt  = (bus.count == (AW+1)'(1));
                        w_addr_nxt     = bus.base_addr;
                        w_nxt_addr_nxt = addr_inc(bus.base_addr);
                        w_remain_nxt   = bus.count - (AW+1)'(1);
                        w_state_nxt    = (bus.count == (AW+1)'(1)) ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_room) begin
                    w_en_nxt       = 1'b1;
                    w_en_last_nxt  = (r_remain == (AW+1)'(1));
                    w_addr_nxt     = r_nxt_addr;
                    w_nxt_addr_nxt = addr_inc(r_nxt_addr);
                    w_remain_nxt   = r_remain - (AW+1)'(1);
                    if (r_remain == (AW+1)'(1)) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_last) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // p0: read issue and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_en_last  <= 1'b0;
            r_addr     <= '0;
            r_nxt_addr <= '0;
            r_remain   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_en_last  <= w_en_last_nxt;
            r_addr     <= w_addr_nxt;
            r_nxt_addr <= w_nxt_addr_nxt;
            r_remain   <= w_remain_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // p1: ROM sampled the read, p2: dout captured into head or FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld_p1  <= 1'b0;
            r_rd_last_p1 <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_fcnt       <= 2'd0;
        end else begin
            r_rd_vld_p1  <= r_en;
            r_rd_last_p1 <= r_en_last;
            if (w_head_free) begin
                r_valid <= w_take_fifo | w_take_push;
                if (w_take_fifo) begin
                    r_data <= r_fmem[r_rp];
                    r_last <= r_flast[r_rp];
                end else if (w_take_push) begin
                    r_data <= bus.dout;
                    r_last <= r_rd_last_p1;
                end
            end
            if (w_fifo_push) r_wp <= ~r_wp;
            if (w_take_fifo) r_rp <= ~r_rp;
            r_fcnt <= r_fcnt + 2'(w_fifo_push) - 2'(w_take_fifo);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_push) begin
            r_fmem[r_wp]  <= bus.dout;
            r_flast[r_wp] <= r_rd_last_p1;
        end
    end

`ifdef ROM_READER_CHKSUM_EN
    logic [width-1:0] r_chksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_chksum <= '0;
        else if (w_burst_start) r_chksum <= '0;
        else if (w_pop)         r_chksum <= r_chksum ^ r_data;
    end

    assign bus.chksum = r_chksum;
`endif

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.en      = r_en;
    assign bus.addr    = r_addr;
    assign bus.m_data  = r_data;
    assign bus.m_valid = r_valid;
    assign bus.m_last  = r_last;
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a registered ROM model, mem[i] = 8'hA0 + i.
module tb_rom_stream_reader;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    logic [W-1:0] rom [D];
    logic [W-1:0] q_data [$];
    logic         q_last [$];
    int           q_cyc  [$];
    int           q_addr [$];
    int           n_done = 0;

    rom_stream_reader_if #(.width(W), .depth(D)) bus();

    rom_stream_reader #(.width(W), .depth(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.en) bus.dout <= rom[bus.addr];

    // Records handshakes, issued reads and done pulses half a cycle ahead of the edge that acts on them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.m_valid && bus.m_ready) begin
                q_data.push_back(bus.m_data);
                q_last.push_back(bus.m_last);
                q_cyc.push_back(cyc);
            end
            if (bus.en) q_addr.push_back(int'(bus.addr));
            if (bus.done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
        q_addr.delete();
        n_done = 0;
    endtask

    task automatic start_burst(input int base, input int cnt);
        bus.base_addr = AW'(base);
        bus.count     = (AW+1)'(cnt);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [AW+W+5:0] obs;
        rst_n = 1'b0;
        repeat (3) tick();
        obs = {bus.busy, bus.done, bus.en, bus.addr, bus.m_valid, bus.m_data, bus.m_last};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
`ifdef ROM_READER_CHKSUM_EN
        checks++;
        if (bus.chksum !== 8'h00) begin
            failures++;
            $display("FAIL reset_chksum got=%h want=00", bus.chksum);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        clear_mon();
        bus.m_ready = 1'b1;
        start_burst(0, 4);
        checks++;
        if ({bus.en, bus.addr} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL basic_first_read en/addr got=%b/%0d want=1/0", bus.en, bus.addr);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid got=%b want=0", bus.m_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({bus.m_valid, bus.m_data, bus.m_last} !== {1'b1, 8'(8'hA0 + k), (k == 3)}) begin
                failures++;
                $display("FAIL basic_word%0d valid/data/last got=%b/%h/%b want=1/%h/%b",
                         k, bus.m_valid, bus.m_data, bus.m_last, 8'(8'hA0 + k), (k == 3));
            end
        end
        tick();
        checks++;
        if ({bus.done, bus.busy, bus.m_valid} !== 3'b100) begin
            failures++;
            $display("FAIL basic_done done/busy/valid got=%b%b%b want=100", bus.done, bus.busy, bus.m_valid);
        end
`ifdef ROM_READER_CHKSUM_EN
        checks++;
        if (bus.chksum !== 8'h00) begin
            failures++;
            $display("FAIL basic_chksum got=%h want=00", bus.chksum);
        end
`endif
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_width got=%b want=0", bus.done);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int exp_addr [4] = '{14, 15, 0, 1};
        logic [W-1:0] exp_data [4] = '{8'hAE, 8'hAF, 8'hA0, 8'hA1};
        clear_mon();
        start_burst(14, 4);
        wait_done(ok);
        checks++;
        if (!ok || q_data.size() != 4 || q_addr.size() != 4) begin
            failures++;
            $display("FAIL wrap_counts done=%0d words=%0d reads=%0d want 1/4/4", ok, q_data.size(), q_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_addr[i] != exp_addr[i] || q_data[i] !== exp_data[i] || q_last[i] !== (i == 3)) begin
                    failures++;
                    $display("FAIL wrap_word%0d addr/data/last got=%0d/%h/%b want=%0d/%h/%b",
                             i, q_addr[i], q_data[i], q_last[i], exp_addr[i], exp_data[i], (i == 3));
                end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        bus.m_ready = 1'b1;
        start_burst(0, 6);
        for (int i = 0; i < 10 && q_data.size() < 1; i++) tick();
        bus.m_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            checks++;
            if (bus.en !== 1'b0 || bus.m_valid !== 1'b1 || bus.m_data !== 8'hA1
                || (q_addr.size() - q_data.size()) > 3) begin
                failures++;
                $display("FAIL bp_stall%0d en/valid/data/inflight got=%b/%b/%h/%0d want=0/1/a1/<=3",
                         s, bus.en, bus.m_valid, bus.m_data, q_addr.size() - q_data.size());
            end
        end
        bus.m_ready = 1'b1;
        wait_done(ok);
        checks++;
        if (!ok || q_data.size() != 6 || q_addr.size() != 6) begin
            failures++;
            $display("FAIL bp_counts done=%0d words=%0d reads=%0d want 1/6/6", ok, q_data.size(), q_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (q_addr[i] != i || q_data[i] !== 8'(8'hA0 + i) || q_last[i] !== (i == 5)) begin
                    failures++;
                    $display("FAIL bp_word%0d addr/data/last got=%0d/%h/%b want=%0d/%h/%b",
                             i, q_addr[i], q_data[i], q_last[i], i, 8'(8'hA0 + i), (i == 5));
                end
            end
            checks++;
            if (q_cyc[1] - q_cyc[0] != 5 || q_cyc[5] - q_cyc[1] != 4) begin
                failures++;
                $display("FAIL bp_resume_gap got=%0d,%0d want=5,4", q_cyc[1] - q_cyc[0], q_cyc[5] - q_cyc[1]);
            end
        end
`ifdef ROM_READER_CHKSUM_EN
        tick();
        checks++;
        if (bus.chksum !== 8'h01) begin
            failures++;
            $display("FAIL bp_chksum_hold got=%h want=01", bus.chksum);
        end
`endif
        tick();
    endtask

    task automatic test_zero_and_busy();
        bit ok;
        clear_mon();
        start_burst(5, 0);
        checks++;
        if ({bus.done, bus.busy, bus.en} !== 3'b100) begin
            failures++;
            $display("FAIL zero_done done/busy/en got=%b%b%b want=100", bus.done, bus.busy, bus.en);
        end
        tick();
        checks++;
        if ({bus.done, bus.en, q_addr.size()} !== {2'b00, 32'd0}) begin
            failures++;
            $display("FAIL zero_after done/en/reads got=%b/%b/%0d want=0/0/0", bus.done, bus.en, q_addr.size());
        end
        clear_mon();
        start_burst(0, 4);
        tick();
        start_burst(8, 3);
        wait_done(ok);
        repeat (4) tick();
        checks++;
        if (!ok || q_data.size() != 4 || q_addr.size() != 4 || n_done != 1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start done=%0d words=%0d reads=%0d pulses=%0d busy=%b want 1/4/4/1/0",
                     ok, q_data.size(), q_addr.size(), n_done, bus.busy);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_addr[i] != i || q_data[i] !== 8'(8'hA0 + i) || q_last[i] !== (i == 3)) begin
                    failures++;
                    $display("FAIL busy_word%0d addr/data/last got=%0d/%h/%b want=%0d/%h/%b",
                             i, q_addr[i], q_data[i], q_last[i], i, 8'(8'hA0 + i), (i == 3));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [AW+W+5:0] obs;
        clear_mon();
        bus.m_ready = 1'b1;
        start_burst(0, 6);
        for (int i = 0; i < 10 && q_data.size() < 2; i++) tick();
        rst_n = 1'b0;
        #1;
        obs = {bus.busy, bus.done, bus.en, bus.addr, bus.m_valid, bus.m_data, bus.m_last};
        checks++;
        if (q_data.size() != 2 || obs !== '0) begin
            failures++;
            $display("FAIL midreset_outputs words=%0d got=%h want=2/0", q_data.size(), obs);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        start_burst(3, 2);
        wait_done(ok);
        checks++;
        if (!ok || q_data.size() != 2 || q_addr.size() != 2) begin
            failures++;
            $display("FAIL midreset_counts done=%0d words=%0d reads=%0d want 1/2/2", ok, q_data.size(), q_addr.size());
        end else begin
            checks++;
            if ({q_data[0], q_last[0], q_data[1], q_last[1]} !== {8'hA3, 1'b0, 8'hA4, 1'b1}
                || q_addr[0] != 3 || q_addr[1] != 4) begin
                failures++;
                $display("FAIL midreset_words got=%h/%b %h/%b addr=%0d,%0d want=a3/0 a4/1 addr=3,4",
                         q_data[0], q_last[0], q_data[1], q_last[1], q_addr[0], q_addr[1]);
            end
        end
`ifdef ROM_READER_CHKSUM_EN
        checks++;
        if (bus.chksum !== 8'h07) begin
            failures++;
            $display("FAIL midreset_chksum got=%h want=07", bus.chksum);
        end
`endif
        tick();
    endtask

    initial begin
        for (int i = 0; i < D; i++) rom[i] = 8'(8'hA0 + i);
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        bus.m_ready   = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
